alu_ctrl_seq: RTL
=================

Name: alu_ctrl_seq

Overview:
- Second-generation ALU control for the RISC-V core. It decodes i_aluop, i_opcode, i_funct3 and i_funct7 into a parametrised ALU operation code, and adds RV32M, SRA/SRAI, SLTU and LUI pass-through.
- It registers the decoded operation behind a valid/ready handshake.
- It sequences multi-cycle operations (multiply, divide) with a latency counter, and exposes a busy/stall to the hazard unit.
- It sits between the main decoder and the execute stage.

Parameters:
- OP_W, 5: width of o_alu_operation; must be >= 5.
- M_EXT, 1: 1 decodes RV32M; 0 makes funct7=0x01 illegal.
- MUL_LAT, 2: cycles from accept to o_valid for MUL/MULH/MULHSU/MULHU; range 1..255.
- DIV_LAT, 33: cycles from accept to o_valid for DIV/DIVU/REM/REMU; range 1..255.
- CNT_W: localparam, $clog2(max(MUL_LAT,DIV_LAT)+1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_flush  in  1  kill the in-flight operation (branch/trap).
- i_valid  in  1  decode fields valid.
- o_ready  out  1  block can accept this cycle.
- i_opcode  in  7  instruction opcode.
- i_funct7  in  7  instruction funct7.
- i_funct3  in  3  instruction funct3.
- i_aluop  in  3  main-decoder ALU class.
- o_valid  out  1  o_alu_operation/o_illegal valid.
- i_ready  in  1  execute stage consumes the output.
- o_alu_operation  out  OP_W  registered operation code.
- o_illegal  out  1  registered: encoding not supported.
- o_busy  out  1  multi-cycle operation in progress (stall).

Behaviour:
- Reset and synchronicity:
  - One clock; reset is synchronous and active-high.
  - On i_rst: state=IDLE, counter=0, o_valid=0, o_alu_operation=0, o_illegal=0, o_busy=0.
- Operation codes (zero-extended to OP_W):
  - 0x00 ADD, 0x01 SUB, 0x02 MUL, 0x03 SLL, 0x04 SLT, 0x05 XOR, 0x06 SRL, 0x07 OR, 0x08 AND, 0x09 SLLI, 0x0A SRLI.
  - 0x0B SRA, 0x0C SRAI, 0x0D SLTU, 0x0E PASS_B.
  - 0x10 MULH, 0x11 MULHSU, 0x12 MULHU, 0x13 DIV, 0x14 DIVU, 0x15 REM, 0x16 REMU.
- Decode by i_aluop:
  - 0 → ADD.
  - 1 → SUB.
  - 3 → PASS_B (LUI).
  - 4 → SLTU (BLTU/BGEU).
  - 2 → funct decode, below.
  - 5..7 → ADD with illegal=1.
- Funct decode, R-type (0110011):
  - funct7=0x00: funct3 0..7 → ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7=0x20: funct3 0 → SUB, funct3 5 → SRA; other funct3 illegal.
  - funct7=0x01 (M_EXT=1): funct3 0..7 → MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Any other funct7 is illegal.
- Funct decode, I-type (0010011):
  - funct3 0 ADD, 2 SLT, 3 SLTU, 4 XOR, 6 OR, 7 AND.
  - funct3 1 → SLLI only if funct7=0x00.
  - funct3 5 → SRLI if funct7=0x00, SRAI if funct7=0x20.
  - Otherwise illegal.
- Any other opcode under aluop 2 is illegal.
- Illegal encodings always produce op=ADD, o_illegal=1, latency 1.
- Latency L:
  - MUL_LAT for 0x02 and 0x10–0x12.
  - DIV_LAT for 0x13–0x16.
  - 1 for everything else.
- FSM: IDLE, EXEC, HOLD.
- o_ready = (state==IDLE) || (state==HOLD && i_ready), forced 0 when i_flush.
- Accept = i_valid && o_ready. On accept:
  - Register op and illegal.
  - If L==1 → HOLD (o_valid=1 next cycle).
  - Else → EXEC with counter=L-1 and o_busy=1.
- EXEC:
  - Counter decrements each cycle.
  - When counter==1, next state is HOLD; o_busy drops and o_valid rises on the same edge.
  - Net effect: o_valid rises exactly L cycles after the accept edge.
- HOLD:
  - o_valid=1.
  - Outputs stable until i_ready.
  - i_ready without a new accept → IDLE.
  - i_ready with a new accept → reload (back-to-back, throughput 1 op/cycle for L=1).
- i_flush has priority over accept and over count completion. Next cycle: state=IDLE, o_valid=0, o_busy=0, counter=0; o_alu_operation holds its last value.
- i_rst mid-EXEC or mid-HOLD: identical to the reset values; no o_valid pulse afterwards.
- Inputs are sampled only on accept; changes while not ready are ignored.

Decomposition:
- Package alu_ctrl_pkg:
  - opcode constants R_TYPE, I_TYPE.
  - aluop class constants.
  - ALU operation code localparams (ADD..REMU).
  - latency-class enum (SINGLE, MUL, DIV).
- Sub-module alu_ctrl_decode: purely combinational field decode → {op, illegal, lat_class}.
- alu_ctrl_seq: handshake FSM and counter.

Test Plan:
- Reset → o_valid=0, o_busy=0, o_alu_operation=0, o_ready=1. R-type funct3=0 funct7=0x20 with i_ready=1 → o_alu_operation=0x01 one cycle after accept, o_illegal=0.
- Back-to-back I-type funct3=5 funct7=0x20, then funct7=0x00, i_ready held 1 → ops 0x0C then 0x0A on consecutive cycles; o_ready never drops.
- DIVU (R, funct7=0x01, funct3=5), DIV_LAT=33 → o_busy=1 for 32 cycles, o_valid rises on cycle 33 with 0x14; o_ready=0 throughout EXEC.
- MUL accept, then i_flush 1 cycle later → next cycle o_busy=0, o_valid=0, state IDLE; a subsequent ADD is accepted normally.
- Illegal cases → op=0x00, o_illegal=1, latency 1:
  - R funct7=0x20 funct3=1.
  - R funct7=0x01 with M_EXT=0.
  - opcode 0x63 under aluop 2.
- HOLD with i_ready=0 for 5 cycles while i_valid presents another op → o_alu_operation stable, o_ready=0. Raise i_ready → the new op is accepted on that edge.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared constants and types for the second-generation ALU control block:
// instruction opcode and funct7 encodings, main-decoder ALU class codes,
// ALU operation codes, the latency-class enum and the sequencer state enum.
// ----------------------------------------------------------------------------
package alu_ctrl_pkg;

    // Native width of the operation code; the top zero-extends to OP_W.
    localparam int ALU_OP_W = 5;

    // Instruction opcodes handled by the funct decode.
    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_I_TYPE = 7'b0010011;

    // funct7 encodings.
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    // Main-decoder ALU classes (i_aluop). 5..7 are reserved.
    localparam logic [2:0] ALUOP_ADD   = 3'd0;
    localparam logic [2:0] ALUOP_SUB   = 3'd1;
    localparam logic [2:0] ALUOP_FUNCT = 3'd2;
    localparam logic [2:0] ALUOP_LUI   = 3'd3;
    localparam logic [2:0] ALUOP_SLTU  = 3'd4;

    // ALU operation codes.
    localparam logic [ALU_OP_W-1:0] OP_ADD    = 5'h00;
    localparam logic [ALU_OP_W-1:0] OP_SUB    = 5'h01;
    localparam logic [ALU_OP_W-1:0] OP_MUL    = 5'h02;
    localparam logic [ALU_OP_W-1:0] OP_SLL    = 5'h03;
    localparam logic [ALU_OP_W-1:0] OP_SLT    = 5'h04;
    localparam logic [ALU_OP_W-1:0] OP_XOR    = 5'h05;
    localparam logic [ALU_OP_W-1:0] OP_SRL    = 5'h06;
    localparam logic [ALU_OP_W-1:0] OP_OR     = 5'h07;
    localparam logic [ALU_OP_W-1:0] OP_AND    = 5'h08;
    localparam logic [ALU_OP_W-1:0] OP_SLLI   = 5'h09;
    localparam logic [ALU_OP_W-1:0] OP_SRLI   = 5'h0A;
    localparam logic [ALU_OP_W-1:0] OP_SRA    = 5'h0B;
    localparam logic [ALU_OP_W-1:0] OP_SRAI   = 5'h0C;
    localparam logic [ALU_OP_W-1:0] OP_SLTU   = 5'h0D;
    localparam logic [ALU_OP_W-1:0] OP_PASS_B = 5'h0E;
    localparam logic [ALU_OP_W-1:0] OP_MULH   = 5'h10;
    localparam logic [ALU_OP_W-1:0] OP_MULHSU = 5'h11;
    localparam logic [ALU_OP_W-1:0] OP_MULHU  = 5'h12;
    localparam logic [ALU_OP_W-1:0] OP_DIV    = 5'h13;
    localparam logic [ALU_OP_W-1:0] OP_DIVU   = 5'h14;
    localparam logic [ALU_OP_W-1:0] OP_REM    = 5'h15;
    localparam logic [ALU_OP_W-1:0] OP_REMU   = 5'h16;

    // Which latency parameter applies to a decoded operation.
    typedef enum logic [1:0] {
        LAT_SINGLE,
        LAT_MUL,
        LAT_DIV
    } lat_class_e;

    // Handshake sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ----------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational decode of the main-decoder ALU class and the
// instruction fields into an ALU operation code, an illegal flag and a
// latency class. Illegal encodings always yield ADD with single latency.
//
// Ports:
//   aluop_i   [2:0]  main-decoder ALU class
//   opcode_i  [6:0]  instruction opcode
//   funct7_i  [6:0]  instruction funct7
//   funct3_i  [2:0]  instruction funct3
//   op_o      [4:0]  decoded ALU operation
//   illegal_o        encoding not supported
//   lat_o            latency class of op_o
// ----------------------------------------------------------------------------
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [2:0]          aluop_i,
    input  logic [6:0]          opcode_i,
    input  logic [6:0]          funct7_i,
    input  logic [2:0]          funct3_i,
    output logic [ALU_OP_W-1:0] op_o,
    output logic                illegal_o,
    output lat_class_e          lat_o
);

    // NOTE: every output gets a default before the case tree, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        op_o      = OP_ADD;
        illegal_o = 1'b0;
        lat_o     = LAT_SINGLE;

        case (aluop_i)
            ALUOP_ADD:  op_o = OP_ADD;
            ALUOP_SUB:  op_o = OP_SUB;
            ALUOP_LUI:  op_o = OP_PASS_B;
            ALUOP_SLTU: op_o = OP_SLTU;
            ALUOP_FUNCT: begin
                if (opcode_i == OPC_R_TYPE) begin
                    if (funct7_i == F7_BASE) begin
                        case (funct3_i)
                            3'd0: op_o = OP_ADD;
                            3'd1: op_o = OP_SLL;
                            3'd2: op_o = OP_SLT;
                            3'd3: op_o = OP_SLTU;
                            3'd4: op_o = OP_XOR;
                            3'd5: op_o = OP_SRL;
                            3'd6: op_o = OP_OR;
                            3'd7: op_o = OP_AND;
                        endcase
                    end else if (funct7_i == F7_ALT) begin
                        if (funct3_i == 3'd0)      op_o = OP_SUB;
                        else if (funct3_i == 3'd5) op_o = OP_SRA;
                        else                       illegal_o = 1'b1;
                    end else if (funct7_i == F7_MULDIV && M_EXT != 0) begin
                        case (funct3_i)
                            3'd0: op_o = OP_MUL;
                            3'd1: op_o = OP_MULH;
                            3'd2: op_o = OP_MULHSU;
                            3'd3: op_o = OP_MULHU;
                            3'd4: op_o = OP_DIV;
                            3'd5: op_o = OP_DIVU;
                            3'd6: op_o = OP_REM;
                            3'd7: op_o = OP_REMU;
                        endcase
                        // funct3[2] separates the divide group from multiply.
                        lat_o = funct3_i[2] ? LAT_DIV : LAT_MUL;
                    end else begin
                        illegal_o = 1'b1;
                    end
                end else if (opcode_i == OPC_I_TYPE) begin
                    case (funct3_i)
                        3'd0: op_o = OP_ADD;
                        3'd2: op_o = OP_SLT;
                        3'd3: op_o = OP_SLTU;
                        3'd4: op_o = OP_XOR;
                        3'd6: op_o = OP_OR;
                        3'd7: op_o = OP_AND;
                        3'd1: begin
                            if (funct7_i == F7_BASE) op_o = OP_SLLI;
                            else                     illegal_o = 1'b1;
                        end
                        3'd5: begin
                            if (funct7_i == F7_BASE)     op_o = OP_SRLI;
                            else if (funct7_i == F7_ALT) op_o = OP_SRAI;
                            else                         illegal_o = 1'b1;
                        end
                    endcase
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase

        // Illegal encodings collapse to a single-cycle ADD.
        if (illegal_o) begin
            op_o  = OP_ADD;
            lat_o = LAT_SINGLE;
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ----------------------------------------------------------------------------
// alu_ctrl_seq
// ALU control between the main decoder and the execute stage. Decodes the
// ALU class and instruction fields, registers the operation behind a
// valid/ready handshake and holds multi-cycle operations (multiply/divide)
// in EXEC for their latency, raising o_busy for the hazard unit.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flush               kill the in-flight operation
//   i_valid / o_ready     input handshake (decode fields valid / can accept)
//   i_opcode, i_funct7,
//   i_funct3, i_aluop     decode fields, sampled only on accept
//   o_valid / i_ready     output handshake towards execute
//   o_alu_operation       registered operation code (OP_W bits)
//   o_illegal             registered: encoding not supported
//   o_busy                multi-cycle operation in progress
// ----------------------------------------------------------------------------
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int M_EXT   = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [6:0]      i_opcode,
    input  logic [6:0]      i_funct7,
    input  logic [2:0]      i_funct3,
    input  logic [2:0]      i_aluop,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [OP_W-1:0] o_alu_operation,
    output logic            o_illegal,
    output logic            o_busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [ALU_OP_W-1:0] dec_op;
    logic                dec_illegal;
    lat_class_e          dec_lat_class;
    logic [CNT_W-1:0]    dec_lat;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                illegal_q, illegal_d;
    logic                accept;

    alu_ctrl_decode #(
        .M_EXT (M_EXT)
    ) u_decode (
        .aluop_i   (i_aluop),
        .opcode_i  (i_opcode),
        .funct7_i  (i_funct7),
        .funct3_i  (i_funct3),
        .op_o      (dec_op),
        .illegal_o (dec_illegal),
        .lat_o     (dec_lat_class)
    );

    always_comb begin
        dec_lat = CNT_W'(1);
        case (dec_lat_class)
            LAT_MUL: dec_lat = CNT_W'(MUL_LAT);
            LAT_DIV: dec_lat = CNT_W'(DIV_LAT);
            default: dec_lat = CNT_W'(1);
        endcase
    end

    // A HOLD slot frees up in the same cycle execute takes it, which gives
    // back-to-back single-cycle throughput.
    assign o_ready = !i_flush &&
                     ((state_q == ST_IDLE) || (state_q == ST_HOLD && i_ready));
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        illegal_d = illegal_q;

        if (i_flush) begin
            // Flush beats completion; the operation code is left as is.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_EXEC: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (i_ready) state_d = ST_IDLE;
                end
                default: ;
            endcase

            if (accept) begin
                op_d      = OP_W'(dec_op);
                illegal_d = dec_illegal;
                if (dec_lat == CNT_W'(1)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    // Counter reaches 1 on the edge before the result is due.
                    state_d = ST_EXEC;
                    cnt_d   = dec_lat - CNT_W'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its peers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_valid         = (state_q == ST_HOLD);
    assign o_busy          = (state_q == ST_EXEC);
    assign o_alu_operation = op_q;
    assign o_illegal       = illegal_q;

endmodule
